// File: rtl/keyboard_joy_mapper.sv
// PS/2 set-2 scan-code decoder driving NES joystick vectors and the powerpad.
// Handles E0/F0 prefixes, E1 pause skipping, player select and A/B autofire.
module keyboard_joy_mapper #(
   parameter int NUM_PLAYERS = 2,
   parameter int AF_DIV      = 833333,
   parameter int PREFIX_TO   = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               kbd_data,
   input  logic                     kbd_valid,
   output logic [NUM_PLAYERS*8-1:0] joystick,
   output logic [11:0]              powerpad,
   output logic [1:0]               active_player,
   output logic [1:0]               af_enable
);
   localparam int AF_W = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
   localparam int TO_W = (PREFIX_TO > 1) ? $clog2(PREFIX_TO) : 1;
   localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_DIV - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TO - 1);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

   state_t                  state, state_nx;
   logic [2:0]              skip_cnt, skip_nx;
   logic [TO_W-1:0]         to_cnt, to_nx;
   logic [AF_W-1:0]         af_cnt;
   logic                    phase, phase_nx;
   logic [7:0]              held    [NUM_PLAYERS];
   logic [7:0]              held_nx [NUM_PLAYERS];
   logic [11:0]             pad_nx;
   logic [1:0]              ap_nx, af_nx;
   logic                    q_down, w_down, q_nx, w_nx;
   logic                    key_hit, key_ext, key_make;
   logic [3:0]              ext_l, nrm_l;
   logic [4:0]              pad_l;
   logic [2:0]              sel_l;
   logic [NUM_PLAYERS*8-1:0] joy_nx;

   // {hit, bit index} into the joystick vector for extended (arrow) codes
   function automatic logic [3:0] ext_bit(input logic [7:0] c);
      case (c)
         8'h75:   return 4'b1_100;
         8'h72:   return 4'b1_101;
         8'h6B:   return 4'b1_110;
         8'h74:   return 4'b1_111;
         default: return 4'b0_000;
      endcase
   endfunction

   function automatic logic [3:0] norm_bit(input logic [7:0] c);
      case (c)
         8'h29:   return 4'b1_000;
         8'h11:   return 4'b1_001;
         8'h0D:   return 4'b1_010;
         8'h76:   return 4'b1_011;
         default: return 4'b0_000;
      endcase
   endfunction

   function automatic logic [4:0] pad_idx(input logic [7:0] c);
      case (c)
         8'h24:   return 5'h10;
         8'h2D:   return 5'h11;
         8'h2C:   return 5'h12;
         8'h35:   return 5'h13;
         8'h23:   return 5'h14;
         8'h2B:   return 5'h15;
         8'h34:   return 5'h16;
         8'h33:   return 5'h17;
         8'h21:   return 5'h18;
         8'h2A:   return 5'h19;
         8'h32:   return 5'h1A;
         8'h31:   return 5'h1B;
         default: return 5'h00;
      endcase
   endfunction

   function automatic logic [2:0] sel_idx(input logic [7:0] c);
      case (c)
         8'h16:   return 3'b1_00;
         8'h1E:   return 3'b1_01;
         8'h26:   return 3'b1_10;
         8'h25:   return 3'b1_11;
         default: return 3'b0_00;
      endcase
   endfunction

   always_comb begin
      state_nx = state;
      skip_nx  = skip_cnt;
      to_nx    = to_cnt;
      key_hit  = 1'b0;
      key_ext  = 1'b0;
      key_make = 1'b0;
      if (kbd_valid) begin
         to_nx = '0;
         case (state)
            S_IDLE: begin
               if (kbd_data == 8'hE0)      state_nx = S_EXT;
               else if (kbd_data == 8'hF0) state_nx = S_BRK;
               else if (kbd_data == 8'hE1) begin
                  state_nx = S_SKIP;
                  skip_nx  = 3'd7;
               end else begin
                  key_hit  = 1'b1;
                  key_make = 1'b1;
               end
            end
            S_EXT: begin
               if (kbd_data == 8'hF0)      state_nx = S_EXT_BRK;
               else if (kbd_data == 8'hE0) state_nx = S_EXT;
               else begin
                  key_hit  = 1'b1;
                  key_ext  = 1'b1;
                  key_make = 1'b1;
                  state_nx = S_IDLE;
               end
            end
            S_BRK: begin
               key_hit  = 1'b1;
               state_nx = S_IDLE;
            end
            S_EXT_BRK: begin
               key_hit  = 1'b1;
               key_ext  = 1'b1;
               state_nx = S_IDLE;
            end
            S_SKIP: begin
               skip_nx = skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end else if (state != S_IDLE) begin
         // a prefix with no follow-up byte is abandoned without any key action
         if (to_cnt == TO_LAST) begin
            state_nx = S_IDLE;
            to_nx    = '0;
         end else begin
            to_nx = to_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) held_nx[p] = held[p];
      pad_nx = powerpad;
      ap_nx  = active_player;
      af_nx  = af_enable;
      q_nx   = q_down;
      w_nx   = w_down;
      ext_l  = ext_bit(kbd_data);
      nrm_l  = norm_bit(kbd_data);
      pad_l  = pad_idx(kbd_data);
      sel_l  = sel_idx(kbd_data);
      if (key_hit) begin
         if (key_ext) begin
            for (int p = 0; p < NUM_PLAYERS; p++)
               if (ext_l[3] && active_player == 2'(p)) held_nx[p][ext_l[2:0]] = key_make;
         end else begin
            for (int p = 0; p < NUM_PLAYERS; p++)
               if (nrm_l[3] && active_player == 2'(p)) held_nx[p][nrm_l[2:0]] = key_make;
            if (pad_l[4]) pad_nx[pad_l[3:0]] = key_make;
            // toggle only on the held-flag rising edge so typematic repeats are inert
            if (kbd_data == 8'h15) begin
               if (key_make && !q_down) af_nx[0] = ~af_enable[0];
               q_nx = key_make;
            end
            if (kbd_data == 8'h1D) begin
               if (key_make && !w_down) af_nx[1] = ~af_enable[1];
               w_nx = key_make;
            end
            if (key_make && sel_l[2] && int'(sel_l[1:0]) < NUM_PLAYERS) begin
               for (int p = 0; p < NUM_PLAYERS; p++)
                  if (active_player == 2'(p)) held_nx[p] = 8'h00;
               ap_nx = sel_l[1:0];
            end
         end
      end
   end

   always_comb begin
      phase_nx = (af_cnt == AF_LAST) ? ~phase : phase;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         joy_nx[p*8 +: 8] = held_nx[p];
         joy_nx[p*8]      = held_nx[p][0] & (~af_nx[0] | phase_nx);
         joy_nx[p*8+1]    = held_nx[p][1] & (~af_nx[1] | phase_nx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         skip_cnt      <= '0;
         to_cnt        <= '0;
         af_cnt        <= '0;
         phase         <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) held[p] <= 8'h00;
         powerpad      <= '0;
         active_player <= '0;
         af_enable     <= '0;
         q_down        <= 1'b0;
         w_down        <= 1'b0;
         joystick      <= '0;
      end else begin
         state         <= state_nx;
         skip_cnt      <= skip_nx;
         to_cnt        <= to_nx;
         af_cnt        <= (af_cnt == AF_LAST) ? '0 : af_cnt + 1'b1;
         phase         <= phase_nx;
         for (int p = 0; p < NUM_PLAYERS; p++) held[p] <= held_nx[p];
         powerpad      <= pad_nx;
         active_player <= ap_nx;
         af_enable     <= af_nx;
         q_down        <= q_nx;
         w_down        <= w_nx;
         joystick      <= joy_nx;
      end
   end
endmodule
